// File: rtl/mpc_mvmult_row_seq_if.sv
// ----------------------------------------------------------------------------
// mpc_mvmult_row_seq_if : start/busy, H-ROM, x-memory and y-result signals
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface mpc_mvmult_row_seq_if #(
  parameter int AW = 5,
  parameter int HW = 18,
  parameter int XW = 32
);
  logic          start;
  logic          busy;
  logic [AW-1:0] h_address0;
  logic          h_ce0;
  logic [HW-1:0] h_q0;
  logic [AW-1:0] x_address0;
  logic          x_ce0;
  logic [XW-1:0] x_q0;
  logic [XW-1:0] y;
  logic          y_valid;
  logic          y_ready;

  modport master (
    output start, h_q0, x_q0, y_ready,
    input  busy, h_address0, h_ce0, x_address0, x_ce0, y, y_valid
  );

  modport slave (
    input  start, h_q0, x_q0, y_ready,
    output busy, h_address0, h_ce0, x_address0, x_ce0, y, y_valid
  );
endinterface

`default_nettype wire

// File: rtl/mpc_mvmult_row_seq.sv
// ----------------------------------------------------------------------------
// mpc_mvmult_row_seq : one-row H*x dot product (ROM/x walk, pipelined MAC)
// Optional MVROW_SAT_EN: saturate y to signed XW range instead of wrapping.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mpc_mvmult_row_seq #(
  parameter int N    = 24,
  parameter int AW   = 5,
  parameter int HW   = 18,
  parameter int XW   = 32,
  parameter int FRAC = 16,
  parameter int ACCW = 56
) (
  input wire logic            clk,
  input wire logic            reset,
  mpc_mvmult_row_seq_if.slave bus
);

  localparam logic [1:0]    c_IDLE  = 2'd0;
  localparam logic [1:0]    c_ISSUE = 2'd1;
  localparam logic [1:0]    c_DRAIN = 2'd2;
  localparam logic [1:0]    c_DONE  = 2'd3;
  localparam int            c_PW    = HW + XW;
  localparam logic [AW-1:0] c_LAST  = AW'(N - 1);
  localparam logic [AW-1:0] c_ONE   = AW'(1);

  logic [1:0]             r_state;
  logic [1:0]             w_next;
  logic [AW-1:0]          r_index;
  logic                   r_v1;
  logic                   r_v2;
  logic signed [c_PW-1:0] r_prod;
  logic signed [c_PW-1:0] w_hx;
  logic signed [c_PW-1:0] w_xx;
  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] w_shift;
  logic [XW-1:0]          r_y;
  logic [XW-1:0]          w_ynext;
  logic                   w_issue;
  logic                   w_empty;
  logic                   w_load;

  assign w_empty = !r_v1 && !r_v2;
  assign w_load  = (r_state == c_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (bus.start)          w_next = c_ISSUE;
      c_ISSUE: if (r_index == c_LAST)  w_next = c_DRAIN;
      c_DRAIN: if (w_empty)            w_next = c_DONE;
      c_DONE:  if (bus.y_ready)        w_next = c_IDLE;
      default:                         w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_issue     = 1'b0;
    bus.busy    = 1'b1;
    bus.y_valid = 1'b0;
    case (r_state)
      c_IDLE:  bus.busy    = 1'b0;
      c_ISSUE: w_issue     = 1'b1;
      c_DONE:  bus.y_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.h_ce0      = w_issue;
  assign bus.x_ce0      = w_issue;
  assign bus.h_address0 = r_index;
  assign bus.x_address0 = r_index;
  assign bus.y          = r_y;

  // Operands widened first so the product is formed at full HW+XW precision.
  assign w_hx    = c_PW'($signed(bus.h_q0));
  assign w_xx    = c_PW'($signed(bus.x_q0));
  assign w_shift = r_acc >>> FRAC;

`ifdef MVROW_SAT_EN
  logic [ACCW-XW:0] w_hi;
  assign w_hi = w_shift[ACCW-1:XW-1];
  always_comb begin
    w_ynext = XW'(w_shift);
    if (!((&w_hi) || !(|w_hi)))
      w_ynext = w_shift[ACCW-1] ? {1'b1, {(XW-1){1'b0}}} : {1'b0, {(XW-1){1'b1}}};
  end
`else
  assign w_ynext = XW'(w_shift);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_index <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_y     <= '0;
    end else begin
      r_v1 <= w_issue;
      r_v2 <= r_v1;
      if (r_v1) r_prod <= w_hx * w_xx;
      if (w_load) begin
        r_acc   <= '0;
        r_index <= '0;
      end else begin
        if (r_v2) r_acc <= r_acc + ACCW'(r_prod);
        if (w_issue && (r_index != c_LAST)) r_index <= r_index + c_ONE;
      end
      if ((r_state == c_DRAIN) && w_empty) r_y <= w_ynext;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mpc_mvmult_row_seq.sv
// ----------------------------------------------------------------------------
// tb_mpc_mvmult_row_seq : directed self-checking bench for mpc_mvmult_row_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mpc_mvmult_row_seq;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mpc_mvmult_row_seq_if bus ();

  mpc_mvmult_row_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [17:0] rom [24];
  logic [31:0] xm  [24];

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.h_ce0) bus.h_q0 <= rom[bus.h_address0];
    if (bus.x_ce0) bus.x_q0 <= xm[bus.x_address0];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 24; i++) begin
      rom[i] = '0;
      xm[i]  = '0;
    end
  endtask

  task automatic load_basic();
    clear_mem();
    rom[17] = 18'h10000;
    xm[17]  = 32'h0005_0000;
    rom[21] = 18'h30000;
    xm[21]  = 32'h0002_0000;
  endtask

  // Pulses start, then waits (bounded) for y_valid; cyc is the cycle index with start at 0.
  task automatic run_row(output logic [31:0] yv, output int cyc);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cyc = 1;
    while (!bus.y_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    yv = bus.y;
  endtask

  logic [31:0] yv;
  logic [31:0] yhold;
  int          cyc;
  int          bad;

  initial begin
    bus.start   = 1'b0;
    bus.y_ready = 1'b0;
    clear_mem();

    // Reset held for three cycles
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.h_ce0 || bus.x_ce0) bad++;
    end
    check("rst_no_ce", 32'(bad), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_addr", {16'(bus.h_address0), 16'(bus.x_address0)}, 32'd0);
    check("rst_y", bus.y, 32'd0);
    check("rst_y_valid", 32'(bus.y_valid), 32'd0);
    reset = 1'b1;

    // Basic row with address sequence and latency
    load_basic();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 24; k++) begin
      if (!(bus.h_ce0 && bus.x_ce0 && bus.busy &&
            bus.h_address0 == 5'(k - 1) && bus.x_address0 == 5'(k - 1))) bad++;
      @(negedge clk);
    end
    check("addr_seq", 32'(bad), 32'd0);
    check("drain_ce_off", {31'd0, bus.h_ce0 | bus.x_ce0}, 32'd0);
    check("drain_addr_hold", 32'(bus.h_address0), 32'd23);
    cyc = 25;
    while (!bus.y_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("basic_latency", 32'(cyc), 32'd28);
    check("basic_y", bus.y, 32'h0003_0000);

    // Backpressure with a start pulsed while in DONE
    yhold = bus.y;
    bad   = 0;
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 3);
      @(negedge clk);
      if (!(bus.y_valid && bus.busy && !bus.h_ce0 && !bus.x_ce0 && bus.y === yhold)) bad++;
    end
    bus.start = 1'b0;
    check("stall_hold", 32'(bad), 32'd0);
    bus.y_ready = 1'b1;
    @(negedge clk);
    check("handshake_idle", {30'd0, bus.busy, bus.y_valid}, 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy || bus.h_ce0) bad++;
    end
    check("start_not_queued", 32'(bad), 32'd0);

    // Fractional products at both ends of the row, including the most negative H
    clear_mem();
    rom[0]  = 18'h08000;
    xm[0]   = 32'h0003_0000;
    rom[23] = 18'h20000;
    xm[23]  = 32'h0000_8000;
    run_row(yv, cyc);
    check("frac_latency", 32'(cyc), 32'd28);
    check("frac_y", yv, 32'h0000_8000);

    // Negative result truncates toward minus infinity
    clear_mem();
    rom[2] = 18'h0AF12;
    xm[2]  = 32'hFFFF_FFFF;
    run_row(yv, cyc);
    check("negtrunc_y", yv, 32'hFFFF_FFFF);

    // Overflow of the XW result range
    for (int i = 0; i < 24; i++) begin
      rom[i] = 18'h10000;
      xm[i]  = 32'h7FFF_0000;
    end
    run_row(yv, cyc);
`ifdef MVROW_SAT_EN
    check("overflow_y", yv, 32'h7FFF_FFFF);
`else
    check("overflow_y", yv, 32'hFFE8_0000);
`endif

    // Reset in the middle of a row, then a clean row
    @(negedge clk);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrow_active", {30'd0, bus.busy, bus.h_ce0}, 32'd3);
    reset = 1'b0;
    @(negedge clk);
    check("midrow_rst_busy_ce", {29'd0, bus.busy, bus.h_ce0, bus.x_ce0}, 32'd0);
    check("midrow_rst_y", bus.y, 32'd0);
    @(negedge clk);
    check("midrow_rst_ce2", {30'd0, bus.h_ce0, bus.x_ce0}, 32'd0);
    reset = 1'b1;
    load_basic();
    run_row(yv, cyc);
    check("post_reset_latency", 32'(cyc), 32'd28);
    check("post_reset_y", yv, 32'h0003_0000);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mpc_mvmult_row_seq.md
# mpc_mvmult_row_seq

Sequencer for one row of the ADMM QP matrix-vector product y = H·x. It walks the read-only H-row coefficient ROM and the x-vector memory in lock-step, runs a pipelined signed multiply-accumulate, and returns the dot product as a fixed-point scalar through a valid/ready handshake. One instance per H row; the QP solver's iteration FSM starts it and collects y.

## Interface
- N, 24: row length; ROM and x-vector depth.
- AW, 5: address width, ≥ clog2(N).
- HW, 18: H coefficient width, signed Q2.16.
- XW, 32: x element and y result width, signed Q(XW-16).16.
- FRAC, 16: fractional bits shared by H, x and y.
- ACCW, 56: accumulator width, ≥ HW+XW+clog2(N).

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to compute one row; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- h_address0  out  AW  ROM address.
- h_ce0  out  1  ROM read enable; 1-cycle read latency.
- h_q0  in  HW  ROM data.
- x_address0  out  AW  x-memory address.
- x_ce0  out  1  x-memory read enable; 1-cycle read latency.
- x_q0  in  XW  x data.
- y  out  XW  result; stable while y_valid is high.
- y_valid  out  1  result available.
- y_ready  in  1  consumer accepts y.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: with start=1, clear the accumulator and the index. Go to ISSUE.
- ISSUE: drive h_ce0=x_ce0=1 and h_address0=x_address0=index, with index running 0..N-1, one per cycle. After issuing N-1, go to DRAIN.
- Pipeline, from issue cycle t:
  - t+1: h_q0 and x_q0 valid.
  - t+2: product register p = h_q0·x_q0, signed, HW+XW bits.
  - t+3: acc += sign-extended p.
  - A valid bit travels with each stage. acc updates only on valid stages.
- DRAIN: ce low. Wait until the pipeline holds no valid bits. Then form y and go to DONE.
- Result: y = acc >>> FRAC, arithmetic shift, truncated toward −∞, then narrowed to XW (see Configuration).
- DONE: y_valid=1 and y held. When y_ready=1, go to IDLE.
- start is ignored in ISSUE, DRAIN and DONE. A start in the same cycle as DONE→IDLE is also ignored. start is not queued.
- Addresses stay ≤ N-1. The index does not wrap.
- ce=0 in IDLE, DRAIN and DONE. h_address0 and x_address0 hold their last value.
- Reset low in any state, including mid-row:
  - state goes to IDLE; acc, index, pipeline valid bits and y are cleared.
  - On the next edge, all outputs take their reset values.

## Timing
- Reset values: busy=0, h_ce0=x_ce0=0, h_address0=x_address0=0, y=0, y_valid=0.
- Cycle 0 = start sampled in IDLE.
- Cycles 1..N: address k issued at cycle k+1.
- Last accumulate at cycle N+3.
- y_valid rises at cycle N+4. For N=24 this is cycle 28.
- busy is high from cycle 1 until the cycle after the y handshake.
- Throughput: one row per N+5 cycles when y_ready is tied high. The next start is sampled in IDLE.
- y_ready is sampled only when y_valid=1. Low y_ready stalls DONE indefinitely.

## Configuration
- MVROW_SAT_EN defined: the shifted result saturates to the signed XW range.
  - Max: 0x7FFFFFFF for XW=32.
  - Min: 0x80000000 for XW=32.
- MVROW_SAT_EN undefined: the shifted result is truncated to its low XW bits (two's-complement wrap).

## Test plan
- Reset: hold reset=0 for 3 cycles → all outputs at reset values. No ce while reset is low.
- Basic row: ROM[17]=0x10000 (+1.0), ROM[21]=0x30000 (−1.0), all other ROM entries 0; x[17]=0x00050000, x[21]=0x00020000.
  - Required: pulse start → y=0x00030000 with y_valid rising at cycle 28.
  - Required: address sequence 0..23 on cycles 1..24.
- Backpressure and ignored start: y_ready=0 for 10 cycles after y_valid, with start pulsed in DONE.
  - Required: y held, state stays DONE, no new address issue.
  - Required: y_ready=1 → IDLE on the next cycle.
- Negative truncation: ROM[2]=0x0AF12, x[2]=0xFFFFFFFF (all other ROM entries 0).
  - Required: y = floor(0xAF12·(−1)/2^16) = 0xFFFFFFFF (−1 LSB).
- Overflow: all ROM entries=0x10000, x=0x7FFF0000.
  - With MVROW_SAT_EN: y=0x7FFFFFFF.
  - Without MVROW_SAT_EN: y equals the low 32 bits of the exact sum.
- Mid-row reset: assert reset=0 at cycle 10, release, then start a new row.
  - Required: busy=0 and ce=0 during reset.
  - Required: the next row result is unaffected by the partial accumulation.
